// File: rtl/ray_dir_stepper_if.sv
// Ray output stream from ray_dir_stepper to the tracer: one ray per valid/ready transfer.
interface ray_dir_stepper_if #(
    parameter int COL_W = 9
);
    // A ray transfers on a rising edge where o_valid && i_ready; while o_valid
    // is high and i_ready low, o_rayDirX/o_rayDirY/o_col are held stable.
    logic [23:0]      o_rayDirX;
    logic [23:0]      o_rayDirY;
    logic [COL_W-1:0] o_col;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output o_rayDirX,
        output o_rayDirY,
        output o_col,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_rayDirX,
        input  o_rayDirY,
        input  o_col,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/ray_dir_stepper.sv
// Per-column ray direction generator: latches facing/vplane at frame start, then adds a
// fixed step per accepted column. Optional macro RAYDIR_CENTER_EN offsets column 0 to pixel centre.
module ray_dir_stepper #(
    parameter int COLS_LOG2 = 9,
    parameter int COL_W     = COLS_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_frame_start,
    input  logic [23:0]       facingX,
    input  logic [23:0]       facingY,
    input  logic [23:0]       vplaneX,
    input  logic [23:0]       vplaneY,
    ray_dir_stepper_if.master ray,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              dbg_state
);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'((1 << COLS_LOG2) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [23:0] step_x;
    logic [23:0] step_y;
    logic [23:0] start_step_x;
    logic [23:0] start_step_y;
    logic [23:0] start_x;
    logic [23:0] start_y;
    logic        accept;
    logic        last_col;

    // 2*vplane / 2^COLS_LOG2, floor-rounded by the arithmetic shift.
    assign start_step_x = $signed(vplaneX) >>> (COLS_LOG2 - 1);
    assign start_step_y = $signed(vplaneY) >>> (COLS_LOG2 - 1);

`ifdef RAYDIR_CENTER_EN
    assign start_x = facingX - vplaneX + ($signed(start_step_x) >>> 1);
    assign start_y = facingY - vplaneY + ($signed(start_step_y) >>> 1);
`else
    assign start_x = facingX - vplaneX;
    assign start_y = facingY - vplaneY;
`endif

    assign accept   = (state_q == EMIT) && ray.i_ready;
    assign last_col = (ray.o_col == LAST_COL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame start always wins over the final acceptance.
    always_comb begin
        state_d = state_q;
        if (i_frame_start) begin
            state_d = EMIT;
        end else if (accept && last_col) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ray.o_valid = (state_q == EMIT);
        o_busy      = (state_q == EMIT);
        dbg_state   = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_x        <= '0;
            step_y        <= '0;
            ray.o_rayDirX <= '0;
            ray.o_rayDirY <= '0;
            ray.o_col     <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_frame_start) begin
                step_x        <= start_step_x;
                step_y        <= start_step_y;
                ray.o_rayDirX <= start_x;
                ray.o_rayDirY <= start_y;
                ray.o_col     <= '0;
            end else if (accept) begin
                if (last_col) begin
                    o_frame_done <= 1'b1;
                end else begin
                    ray.o_col     <= ray.o_col + 1'b1;
                    ray.o_rayDirX <= ray.o_rayDirX + step_x;
                    ray.o_rayDirY <= ray.o_rayDirY + step_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_ray_dir_stepper.sv
// Bench for ray_dir_stepper: scoreboard of expected (rayX, rayY, col) per accepted column,
// filled from a closed-form model at each frame start.
module tb_ray_dir_stepper;
    localparam int COLS_LOG2 = 9;
    localparam int COL_W     = COLS_LOG2;
    localparam int NCOLS     = 1 << COLS_LOG2;
    localparam int W         = 24 + 24 + COL_W;

`ifdef RAYDIR_CENTER_EN
    localparam logic [23:0] BASIC_COL0_X   = 24'h0007FC;
    localparam logic [23:0] BASIC_COL1_X   = 24'h0007F4;
    localparam logic [23:0] BASIC_LAST_X   = 24'hFFF804;
    localparam logic [23:0] RESTART_COL0_Y = 24'h000804;
    localparam logic [23:0] RESTART_COL1_Y = 24'h00080C;
`else
    localparam logic [23:0] BASIC_COL0_X   = 24'h000800;
    localparam logic [23:0] BASIC_COL1_X   = 24'h0007F8;
    localparam logic [23:0] BASIC_LAST_X   = 24'hFFF808;
    localparam logic [23:0] RESTART_COL0_Y = 24'h000800;
    localparam logic [23:0] RESTART_COL1_Y = 24'h000808;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [23:0] facing_x, facing_y, vplane_x, vplane_y;
    logic        busy, frame_done, dbg_state;

    always #5 clk = ~clk;

    ray_dir_stepper_if #(.COL_W(COL_W)) ray_if ();

    ray_dir_stepper #(.COLS_LOG2(COLS_LOG2), .COL_W(COL_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_frame_start(frame_start),
        .facingX      (facing_x),
        .facingY      (facing_y),
        .vplaneX      (vplane_x),
        .vplaneY      (vplane_y),
        .ray          (ray_if),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .dbg_state    (dbg_state)
    );

    logic [W-1:0] exp_q[$];
    int checks     = 0;
    int errors     = 0;
    int accepted   = 0;
    int done_count = 0;

    // scoreboard: every transfer is compared to the head; a transfer coinciding
    // with a frame start is not consumed, so the head stays
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) done_count++;
            if (ray_if.o_valid && ray_if.i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected col=%0d required=none", ray_if.o_col);
                end else if ({ray_if.o_rayDirX, ray_if.o_rayDirY, ray_if.o_col} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_ray got=%h required=%h",
                             {ray_if.o_rayDirX, ray_if.o_rayDirY, ray_if.o_col}, exp_q[0]);
                end
                if (!frame_start && exp_q.size() != 0) begin
                    exp_q.delete(0);
                    accepted++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // driver tasks (called and returning at posedge+1)
    task automatic push_frame(input logic [23:0] fx, fy, vx, vy);
        logic signed [23:0] sx, sy, x0, y0, ix;
        exp_q.delete();
        sx = $signed(vx) >>> (COLS_LOG2 - 1);
        sy = $signed(vy) >>> (COLS_LOG2 - 1);
        x0 = fx - vx;
        y0 = fy - vy;
`ifdef RAYDIR_CENTER_EN
        x0 = x0 + (sx >>> 1);
        y0 = y0 + (sy >>> 1);
`endif
        for (int i = 0; i < NCOLS; i++) begin
            ix = 24'(i);
            exp_q.push_back({24'(x0 + sx * ix), 24'(y0 + sy * ix), COL_W'(i)});
        end
    endtask

    task automatic start_frame(input logic [23:0] fx, fy, vx, vy);
        facing_x = fx; facing_y = fy; vplane_x = vx; vplane_y = vy;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        push_frame(fx, fy, vx, vy);
    endtask

    task automatic start_basic();
        start_frame(24'h000000, 24'h001000, 24'hFFF800, 24'h000000);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; ray_if.i_ready = 1'b0;
        facing_x = '0; facing_y = '0; vplane_x = '0; vplane_y = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ray_if.o_valid, busy, frame_done, ray_if.o_col, ray_if.o_rayDirX,
             ray_if.o_rayDirY, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b busy=%b done=%b col=%0d x=%h y=%h required=all zero",
                     ray_if.o_valid, busy, frame_done, ray_if.o_col, ray_if.o_rayDirX, ray_if.o_rayDirY);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int done0 = done_count;
        ray_if.i_ready = 1'b1;
        start_basic();
        checks++;
        if (!(ray_if.o_valid === 1'b1 && ray_if.o_col === '0 &&
              ray_if.o_rayDirX === BASIC_COL0_X && ray_if.o_rayDirY === 24'h001000)) begin
            errors++;
            $display("FAIL basic_col0 valid=%b col=%0d x=%h y=%h required=1 0 %h 001000",
                     ray_if.o_valid, ray_if.o_col, ray_if.o_rayDirX, ray_if.o_rayDirY, BASIC_COL0_X);
        end
        @(posedge clk); #1;
        checks++;
        if (!(ray_if.o_col === COL_W'(1) && ray_if.o_rayDirX === BASIC_COL1_X)) begin
            errors++;
            $display("FAIL basic_col1 col=%0d x=%h required=1 %h", ray_if.o_col, ray_if.o_rayDirX, BASIC_COL1_X);
        end
        wait_drain(2 * NCOLS, "basic");
        checks++;
        if (!(frame_done === 1'b1 && ray_if.o_valid === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL basic_done done=%b valid=%b busy=%b required=1 0 0", frame_done, ray_if.o_valid, busy);
        end
        checks++;
        if (!(ray_if.o_rayDirX === BASIC_LAST_X && ray_if.o_col === COL_W'(NCOLS - 1))) begin
            errors++;
            $display("FAIL basic_last x=%h col=%0d required=%h 511", ray_if.o_rayDirX, ray_if.o_col, BASIC_LAST_X);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0 || done_count - done0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulse done=%b pulses=%0d required=0 1", frame_done, done_count - done0);
        end
    endtask

    task automatic test_backpressure();
        int acc0 = accepted;
        int n = 0;
        logic [W-1:0] snap;
        logic held;
        ray_if.i_ready = 1'b1;
        start_basic();
        while (exp_q.size() != 0 && n < 4 * NCOLS) begin
            ray_if.i_ready = (n % 4 == 0) || (n % 4 == 3);
            held = !ray_if.i_ready;
            snap = {ray_if.o_rayDirX, ray_if.o_rayDirY, ray_if.o_col};
            @(posedge clk); #1;
            n++;
            if (held) begin
                checks++;
                if ({ray_if.o_rayDirX, ray_if.o_rayDirY, ray_if.o_col} !== snap) begin
                    errors++;
                    $display("FAIL bp_hold got=%h required=%h", {ray_if.o_rayDirX, ray_if.o_rayDirY, ray_if.o_col}, snap);
                end
            end
        end
        checks++;
        if (accepted - acc0 != NCOLS || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_count accepted=%0d done=%b required=%0d 1", accepted - acc0, frame_done, NCOLS);
        end
        ray_if.i_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_restart();
        int done0 = done_count;
        int acc0 = accepted;
        int n = 0;
        ray_if.i_ready = 1'b1;
        start_basic();
        while (accepted - acc0 < 100 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        start_frame(24'h000000, 24'h001000, 24'h000000, 24'h000800);
        checks++;
        if (!(ray_if.o_valid === 1'b1 && ray_if.o_col === '0 &&
              ray_if.o_rayDirX === 24'h000000 && ray_if.o_rayDirY === RESTART_COL0_Y)) begin
            errors++;
            $display("FAIL restart_col0 valid=%b col=%0d x=%h y=%h required=1 0 000000 %h",
                     ray_if.o_valid, ray_if.o_col, ray_if.o_rayDirX, ray_if.o_rayDirY, RESTART_COL0_Y);
        end
        @(posedge clk); #1;
        checks++;
        if (!(ray_if.o_col === COL_W'(1) && ray_if.o_rayDirY === RESTART_COL1_Y)) begin
            errors++;
            $display("FAIL restart_step col=%0d y=%h required=1 %h", ray_if.o_col, ray_if.o_rayDirY, RESTART_COL1_Y);
        end
        wait_drain(2 * NCOLS, "restart");
        @(posedge clk); #1;
        checks++;
        if (done_count - done0 != 1) begin
            errors++;
            $display("FAIL restart_done_pulses got=%0d required=1", done_count - done0);
        end
    endtask

    task automatic test_back_to_back();
        int done0 = done_count;
        int n = 0;
        ray_if.i_ready = 1'b1;
        start_basic();
        while (exp_q.size() > 1 && n < 2 * NCOLS) begin
            @(posedge clk); #1;
            n++;
        end
        start_frame(24'($urandom_range(0, 24'hFFFFFF)), 24'($urandom_range(0, 24'hFFFFFF)),
                    24'($urandom_range(0, 24'hFFFFFF)), 24'($urandom_range(0, 24'hFFFFFF)));
        checks++;
        if (!(frame_done === 1'b0 && ray_if.o_valid === 1'b1 && ray_if.o_col === '0)) begin
            errors++;
            $display("FAIL b2b_restart done=%b valid=%b col=%0d required=0 1 0", frame_done, ray_if.o_valid, ray_if.o_col);
        end
        wait_drain(2 * NCOLS, "b2b");
        @(posedge clk); #1;
        checks++;
        if (done_count - done0 != 1) begin
            errors++;
            $display("FAIL b2b_done_pulses got=%0d required=1", done_count - done0);
        end
    endtask

    task automatic test_isolation();
        int n = 0;
        ray_if.i_ready = 1'b1;
        start_basic();
        while (exp_q.size() != 0 && n < 8 * NCOLS) begin
            ray_if.i_ready = ($urandom_range(0, 3) != 0);
            if (n == 50) begin
                facing_x = 24'($urandom_range(0, 24'hFFFFFF));
                facing_y = 24'($urandom_range(0, 24'hFFFFFF));
                vplane_x = 24'($urandom_range(0, 24'hFFFFFF));
                vplane_y = 24'($urandom_range(0, 24'hFFFFFF));
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(exp_q.size() == 0 && ray_if.o_rayDirX === BASIC_LAST_X && frame_done === 1'b1)) begin
            errors++;
            $display("FAIL iso_last left=%0d x=%h done=%b required=0 %h 1",
                     exp_q.size(), ray_if.o_rayDirX, frame_done, BASIC_LAST_X);
        end
        ray_if.i_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        ray_if.i_ready = 1'b1;
        start_basic();
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({ray_if.o_valid, busy, frame_done, ray_if.o_col, ray_if.o_rayDirX,
             ray_if.o_rayDirY, dbg_state} !== '0) begin
            errors++;
            $display("FAIL areset_outputs valid=%b busy=%b col=%0d x=%h y=%h required=all zero",
                     ray_if.o_valid, busy, ray_if.o_col, ray_if.o_rayDirX, ray_if.o_rayDirY);
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        ray_if.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ray_if.o_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready_ignored valid=%b busy=%b required=0 0", ray_if.o_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_restart();
        test_back_to_back();
        test_isolation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_dir_stepper.md
# ray_dir_stepper

Generates the per-column ray direction vectors that the ray tracer consumes, one column per accepted handshake. It sits directly downstream of the POV/vector register block. At the start of each frame it latches the live `facing` and `vplane` vectors. It then steps incrementally across the screen: each column costs one add per axis, with no multiply or divide.

## Interface

Parameters:
- `COLS_LOG2`, default 9: log2 of columns per frame (512 columns).
- `COL_W`, default `COLS_LOG2`: width of the column index.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `i_frame_start`  in  1: single-cycle pulse; latch vectors and begin column 0.
- `facingX`, `facingY`  in  24 each: signed Q12.12 facing vector from the POV block.
- `vplaneX`, `vplaneY`  in  24 each: signed Q12.12 view-plane vector from the POV block.
- `o_rayDirX`, `o_rayDirY`  out  24 each: signed Q12.12 ray direction for `o_col`.
- `o_col`  out  `COL_W`: column index of the presented ray.
- `o_valid`  out  1: ray output is valid.
- `i_ready`  in  1: tracer accepts the presented ray.
- `o_busy`  out  1: a frame is in progress (state EMIT).
- `o_frame_done`  out  1: single-cycle pulse after the last column is accepted.

## Operation

States:
- IDLE: `o_valid`=0.
- EMIT: `o_valid`=1.

Reset:
- Asynchronous.
- State IDLE.
- `o_rayDirX`, `o_rayDirY`, `o_col`, the step registers, `o_valid`, `o_busy` and `o_frame_done` all 0.

`i_frame_start` seen at a clock edge, in either state:
- `stepX`/`stepY` ← `vplane >>> (COLS_LOG2-1)`. This is an arithmetic shift, i.e. 2·vplane/2^COLS_LOG2.
- `o_rayDir` ← `facing − vplane` (plus the centre offset, see Configuration).
- `o_col` ← 0.
- State → EMIT.

In EMIT, on an edge where `o_valid && i_ready`:
- If `o_col == 2^COLS_LOG2 − 1`: state → IDLE, `o_frame_done` ← 1 for one cycle. `o_rayDir` and `o_col` hold their last values.
- Otherwise: `o_col` ← `o_col`+1, `o_rayDir` ← `o_rayDir` + step.

Data stability:
- In EMIT, `o_rayDir` and `o_col` are stable while `o_valid && !i_ready`.
- Vector inputs are sampled only on the `i_frame_start` edge. Changes mid-frame are ignored.

Arithmetic:
- 24-bit two's complement throughout.
- Adds and subtracts wrap modulo 2^24, with no saturation.
- Truncation from the shift rounds toward −∞.

## Timing

- Latency: `i_frame_start` at edge N → `o_valid`=1 with column 0 in the cycle after edge N.
- Throughput: one column per cycle when `i_ready` is held high. A full frame takes 2^COLS_LOG2 cycles after start.
- `o_frame_done` is high for exactly the cycle after the final accepting edge.
- Simultaneous `i_frame_start` and an accepting handshake: `i_frame_start` wins.
  - The current column counts as not consumed: no increment, no `o_frame_done`.
  - The frame restarts at column 0 with freshly latched vectors.
  - `o_valid` stays high.
- `i_frame_start` on the same edge as the final column's acceptance: restart wins, so no `o_frame_done`.
- `reset` asserted mid-frame: immediately IDLE with all outputs 0, without waiting for a clock edge.
- `i_ready` in IDLE is ignored.

## Configuration

Macro `RAYDIR_CENTER_EN`:
- Defined: column 0 starts at `facing − vplane + (step >>> 1)`, so every ray passes through the pixel centre, symmetric about `facing`.
- Undefined: column 0 starts at `facing − vplane`, the left edge of the pixel.
- Step size, latency and handshake behaviour are identical in both builds.

## Test plan

All scenarios use `COLS_LOG2`=9 and `RAYDIR_CENTER_EN` undefined.

- **Basic frame:** facing=(0x000000,0x001000), vplane=(0xFFF800,0x000000), pulse start, `i_ready`=1.
  - Column 0: rayDir=(0x000800,0x001000).
  - Column 1: rayDirX=0x0007F8.
  - Column 511: rayDirX=0xFFF808.
  - `o_frame_done` one cycle later, `o_valid` then 0.
- **Backpressure:** same vectors, toggle `i_ready` 1,0,0,1.
  - `o_col` and `o_rayDir` hold during the low cycles.
  - No column is skipped or duplicated; 512 acceptances in total.
- **Restart mid-frame:** start, accept 100 columns, then change vplane to (0x000000,0x000800) and pulse start concurrently with `i_ready`.
  - Next column 0 has rayDir=(0x000000,0x000800).
  - stepY=0x000008.
  - No `o_frame_done` from the aborted frame.
- **Async reset:** assert `reset` between clock edges during EMIT.
  - All outputs 0 before the next edge.
  - After release, `i_ready` alone produces no `o_valid`.
- **Input isolation:** change the facing/vplane inputs mid-frame.
  - Remaining columns follow the originally latched step; column 511 rayDirX is still 0xFFF808.
- **Centre build:** redo the basic frame with `RAYDIR_CENTER_EN` defined.
  - Column 0 rayDirX=0x0007FC.
  - Column 511 rayDirX=0xFFF804.
